// File: rtl/memory_controller.sv
// Two-channel word-addressed controller in front of a single synchronous RAM.
// Requests are arbitrated by a toggling turn bit; each access returns a registered response.
module memory_controller #(
    parameter int unsigned CAPACITY_IN_BYTES = 4096
) (
    input  logic        clock,
    input  logic        clear,

    input  logic        ch0_req_valid,
    input  logic [31:0] ch0_req_address,
    input  logic        ch0_req_write,
    input  logic [31:0] ch0_req_write_data,
    output logic        ch0_req_ready,
    output logic        ch0_resp_valid,
    output logic [31:0] ch0_resp_read_data,
    output logic        ch0_resp_error,
    input  logic        ch0_resp_ready,

    input  logic        ch1_req_valid,
    input  logic [31:0] ch1_req_address,
    input  logic        ch1_req_write,
    input  logic [31:0] ch1_req_write_data,
    output logic        ch1_req_ready,
    output logic        ch1_resp_valid,
    output logic [31:0] ch1_resp_read_data,
    output logic        ch1_resp_error,
    input  logic        ch1_resp_ready
);

    localparam int unsigned ADDR_W = $clog2(CAPACITY_IN_BYTES);
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned WORDS  = CAPACITY_IN_BYTES / 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RESPOND = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        turn_q, turn_d;
    logic        owner_q, owner_d;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic [31:0] mem_q [WORDS];

    logic             sel_valid;
    logic [31:0]      sel_addr;
    logic             sel_write;
    logic [31:0]      sel_wdata;
    logic             sel_resp_ready;
    logic             addr_err;
    logic [IDX_W-1:0] word_idx;
    logic             accept;

    // Only the channel holding the turn can be accepted; the owner drives response acceptance.
    assign sel_valid      = turn_q ? ch1_req_valid      : ch0_req_valid;
    assign sel_addr       = turn_q ? ch1_req_address    : ch0_req_address;
    assign sel_write      = turn_q ? ch1_req_write      : ch0_req_write;
    assign sel_wdata      = turn_q ? ch1_req_write_data : ch0_req_write_data;
    assign sel_resp_ready = owner_q ? ch1_resp_ready    : ch0_resp_ready;

    assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(CAPACITY_IN_BYTES));
    assign word_idx = sel_addr[ADDR_W-1:2];

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        owner_d = owner_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid && !clear) begin
                    accept  = 1'b1;
                    owner_d = turn_q;
                    state_d = RESPOND;
                end else begin
                    turn_d = ~turn_q;
                end
            end
            RESPOND: begin
                if (sel_resp_ready) begin
                    state_d = IDLE;
                    turn_d  = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            turn_q      <= 1'b0;
            owner_q     <= 1'b0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            owner_q <= owner_d;
            if (accept) begin
                resp_err_q  <= addr_err;
                resp_data_q <= (!addr_err && !sel_write) ? mem_q[word_idx] : 32'd0;
            end
        end
    end

    // RAM array keeps its contents across clear.
    always_ff @(posedge clock) begin
        if (accept && !addr_err && sel_write) begin
            mem_q[word_idx] <= sel_wdata;
        end
    end

    // Ready depends only on state, turn and clear, never on any request valid.
    assign ch0_req_ready = (state_q == IDLE) && !turn_q && !clear;
    assign ch1_req_ready = (state_q == IDLE) &&  turn_q && !clear;

    assign ch0_resp_valid     = (state_q == RESPOND) && !owner_q;
    assign ch1_resp_valid     = (state_q == RESPOND) &&  owner_q;
    assign ch0_resp_read_data = ch0_resp_valid ? resp_data_q : 32'd0;
    assign ch1_resp_read_data = ch1_resp_valid ? resp_data_q : 32'd0;
    assign ch0_resp_error     = ch0_resp_valid && resp_err_q;
    assign ch1_resp_error     = ch1_resp_valid && resp_err_q;

endmodule
